dac_spi_tx: RTL and testbench

DAC_SPI_TX -- requirements
Module: dac_spi_tx

---
 rtl/dac_spi_pkg.sv | 41 ++++
 rtl/dac_spi_shift.sv | 66 ++++++
 rtl/dac_spi_tx.sv | 154 +++++++++++++++
 tb/tb_dac_spi_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg: FSM state encoding, DAC frame layout and parameter helpers
// shared by dac_spi_tx and dac_spi_shift.
package dac_spi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT_A = 3'd1,
        GAP_AB  = 3'd2,
        SHIFT_B = 3'd3,
        GAP_LD  = 3'd4,
        LDAC    = 3'd5
    } dac_state_e;

    localparam int FRAME_W    = 16;
    localparam int DATA_W     = 12;
    localparam int FRM_SEL    = 15;
    localparam int FRM_BUF    = 14;
    localparam int FRM_GA_N   = 13;
    localparam int FRM_SHDN_N = 12;

    // Two frames, two gaps and the LDAC pulse (70 half-periods) plus the IDLE/latch cycles.
    function automatic int min_sample_div(input int sck_div);
        return 70 * sck_div + 2;
    endfunction

    function automatic logic [FRAME_W-1:0] build_frame(
        input logic              sel,
        input logic              shdn_n,
        input logic [DATA_W-1:0] data
    );
        logic [FRAME_W-1:0] f;
        f               = '0;
        f[FRM_SEL]      = sel;
        f[FRM_BUF]      = 1'b0;
        f[FRM_GA_N]     = 1'b1;
        f[FRM_SHDN_N]   = shdn_n;
        f[DATA_W-1:0]   = data;
        return f;
    endfunction

endpackage

// File: rtl/dac_spi_shift.sv
// dac_spi_shift: 16-bit MSB-first SPI shifter; each bit is SCK_DIV clk with sck
// low followed by SCK_DIV clk with sck high.
module dac_spi_shift
    import dac_spi_pkg::*;
#(
    parameter int SCK_DIV = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame,
    output logic               sck,
    output logic               sdi,
    output logic               done
);

    // start/done handshake: start is a one-cycle pulse that loads frame and
    // begins shifting on the next cycle; done is high for exactly one cycle,
    // the last cycle of bit 0's high phase, and start must not be pulsed again
    // until done has been seen.
    logic [7:0]         half_cnt;
    logic [3:0]         bit_cnt;
    logic [FRAME_W-1:0] sr;
    logic               active;
    logic               half_end;

    assign half_end = active && (half_cnt == 8'(SCK_DIV - 1));
    assign done     = half_end && sck && (bit_cnt == 4'd0);
    assign sdi      = sr[FRAME_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr       <= '0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            sck      <= 1'b0;
            active   <= 1'b0;
        end else if (start) begin
            sr       <= frame;
            half_cnt <= '0;
            bit_cnt  <= 4'd15;
            sck      <= 1'b0;
            active   <= 1'b1;
        end else if (active) begin
            if (half_end) begin
                half_cnt <= '0;
                if (!sck) begin
                    sck <= 1'b1;
                end else begin
                    sck <= 1'b0;
                    if (bit_cnt == 4'd0) begin
                        // Clearing the register parks sdi low between frames.
                        active <= 1'b0;
                        sr     <= '0;
                    end else begin
                        sr      <= {sr[FRAME_W-2:0], 1'b0};
                        bit_cnt <= bit_cnt - 4'd1;
                    end
                end
            end else begin
                half_cnt <= half_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: periodic dual-channel 12-bit SPI DAC writer (frame A, frame B, LDAC).
// Build option DAC_OFFSET_BINARY_EN: treat samples as two's complement and send offset binary.
module dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int SCK_DIV    = 2,
    parameter int SAMPLE_DIV = 2000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] sample_a,
    input  logic [DATA_W-1:0] sample_b,
    input  logic              ch_en_a,
    input  logic              ch_en_b,
    output logic              cs_n,
    output logic              sck,
    output logic              sdi,
    output logic              ldac_n,
    output logic              sample_strobe,
    output logic              busy,
    output dac_state_e        state_dbg
);

    if (SCK_DIV < 1 || SCK_DIV > 255) begin : g_bad_sck_div
        $error("dac_spi_tx: SCK_DIV must be within 1..255");
    end
    if (SAMPLE_DIV < min_sample_div(SCK_DIV)) begin : g_bad_sample_div
        $error("dac_spi_tx: SAMPLE_DIV too small to fit a full A/B/LDAC sequence");
    end

    localparam int DIV_W = $clog2(SAMPLE_DIV);

    function automatic logic [DATA_W-1:0] to_dac_code(input logic [DATA_W-1:0] s);
`ifdef DAC_OFFSET_BINARY_EN
        return {~s[DATA_W-1], s[DATA_W-2:0]};
`else
        return s;
`endif
    endfunction

    dac_state_e         state, state_nx;
    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    logic [8:0]         gap_cnt;
    logic               gap_end;
    logic [DATA_W-1:0]  data_b_q;
    logic               en_b_q;
    logic               shift_start;
    logic [FRAME_W-1:0] shift_frame;
    logic               shift_done;
    logic               strobe_q;

    assign tick    = enable && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
    assign gap_end = (gap_cnt == 9'(2 * SCK_DIV - 1));

    // Sample-rate divider parks at 0 while disabled so the first frame lands
    // a full SAMPLE_DIV after enable is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!enable || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gap_cnt  <= '0;
            data_b_q <= '0;
            en_b_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state    <= state_nx;
            strobe_q <= (state == LDAC) && gap_end;
            if (state != state_nx) begin
                gap_cnt <= '0;
            end else if (state == GAP_AB || state == GAP_LD || state == LDAC) begin
                gap_cnt <= gap_cnt + 9'd1;
            end else begin
                gap_cnt <= '0;
            end
            // Channel A goes straight into the shifter; channel B waits here.
            if (state == IDLE && tick) begin
                data_b_q <= to_dac_code(sample_b);
                en_b_q   <= ch_en_b;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        shift_start = 1'b0;
        shift_frame = '0;
        cs_n        = 1'b1;
        ldac_n      = 1'b1;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (tick) begin
                    state_nx    = SHIFT_A;
                    shift_start = 1'b1;
                    shift_frame = build_frame(1'b0, ch_en_a, to_dac_code(sample_a));
                end
            end
            SHIFT_A: begin
                cs_n = 1'b0;
                if (shift_done) state_nx = GAP_AB;
            end
            GAP_AB: begin
                if (gap_end) begin
                    state_nx    = SHIFT_B;
                    shift_start = 1'b1;
                    shift_frame = build_frame(1'b1, en_b_q, data_b_q);
                end
            end
            SHIFT_B: begin
                cs_n = 1'b0;
                if (shift_done) state_nx = GAP_LD;
            end
            GAP_LD: begin
                if (gap_end) state_nx = LDAC;
            end
            LDAC: begin
                ldac_n = 1'b0;
                if (gap_end) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                busy     = 1'b0;
            end
        endcase
    end

    dac_spi_shift #(
        .SCK_DIV (SCK_DIV)
    ) u_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .start (shift_start),
        .frame (shift_frame),
        .sck   (sck),
        .sdi   (sdi),
        .done  (shift_done)
    );

    assign sample_strobe = strobe_q;
    assign state_dbg     = state;

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: directed bench for dac_spi_tx with SCK_DIV=2, SAMPLE_DIV=200.
module tb_dac_spi_tx;
    import dac_spi_pkg::*;

    localparam int SCK_DIV    = 2;
    localparam int SAMPLE_DIV = 200;
    localparam int BOUND      = 1000;
    localparam int PIN_CS     = 0;
    localparam int PIN_LDAC   = 1;
    localparam int PIN_STROBE = 2;

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic        en_a;
        logic        en_b;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [11:0] sample_a = '0;
    logic [11:0] sample_b = '0;
    logic        ch_en_a = 1'b0;
    logic        ch_en_b = 1'b0;
    logic        cs_n, sck, sdi, ldac_n, sample_strobe, busy;
    dac_state_e  state_dbg;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [15:0] exp_q[$];
    vec_t        vecs[5];

    dac_spi_tx #(
        .SCK_DIV    (SCK_DIV),
        .SAMPLE_DIV (SAMPLE_DIV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .sample_a      (sample_a),
        .sample_b      (sample_b),
        .ch_en_a       (ch_en_a),
        .ch_en_b       (ch_en_b),
        .cs_n          (cs_n),
        .sck           (sck),
        .sdi           (sdi),
        .ldac_n        (ldac_n),
        .sample_strobe (sample_strobe),
        .busy          (busy),
        .state_dbg     (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic pin(input int sel);
        case (sel)
            PIN_CS:   return cs_n;
            PIN_LDAC: return ldac_n;
            default:  return sample_strobe;
        endcase
    endfunction

    // Count negedges while the selected pin stays at lvl.
    task automatic run_len(input int sel, input logic lvl, output int n);
        n = 0;
        while (pin(sel) == lvl && n < BOUND) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_for(input int sel, input logic lvl, output bit found);
        int n;
        n = 0;
        while (pin(sel) != lvl && n < BOUND) begin
            n++;
            @(negedge clk);
        end
        found = (pin(sel) == lvl);
    endtask

    task automatic capture_frame(output logic [15:0] f, output int len, output bit found);
        logic prev;
        f    = '0;
        len  = 0;
        prev = 1'b0;
        wait_for(PIN_CS, 1'b0, found);
        if (found) begin
            while (cs_n == 1'b0 && len < BOUND) begin
                if (sck && !prev) f = {f[14:0], sdi};
                prev = sck;
                len++;
                @(negedge clk);
            end
        end
    endtask

    task automatic set_inputs(input vec_t v);
        sample_a = v.a;
        sample_b = v.b;
        ch_en_a  = v.en_a;
        ch_en_b  = v.en_b;
    endtask

    initial begin
        logic [15:0] f;
        logic [15:0] exp_f;
        int          len;
        int          t0;
        int          bad;
        bit          found;

`ifdef DAC_OFFSET_BINARY_EN
        vecs[0] = '{12'hABC, 12'h123, 1'b1, 1'b1, 16'h32BC, 16'hB923};
        vecs[1] = '{12'hABC, 12'h123, 1'b1, 1'b0, 16'h32BC, 16'hA923};
        vecs[2] = '{12'h000, 12'hFFF, 1'b0, 1'b1, 16'h2800, 16'hB7FF};
        vecs[3] = '{12'h800, 12'h7FF, 1'b1, 1'b1, 16'h3000, 16'hBFFF};
        vecs[4] = '{12'h7FF, 12'h800, 1'b1, 1'b1, 16'h3FFF, 16'hB000};
`else
        vecs[0] = '{12'hABC, 12'h123, 1'b1, 1'b1, 16'h3ABC, 16'hB123};
        vecs[1] = '{12'hABC, 12'h123, 1'b1, 1'b0, 16'h3ABC, 16'hA123};
        vecs[2] = '{12'h000, 12'hFFF, 1'b0, 1'b1, 16'h2000, 16'hBFFF};
        vecs[3] = '{12'h800, 12'h7FF, 1'b1, 1'b1, 16'h3800, 16'hB7FF};
        vecs[4] = '{12'h7FF, 12'h800, 1'b1, 1'b1, 16'h37FF, 16'hB800};
`endif

        // reset state
        repeat (3) @(negedge clk);
        check("reset_cs_n", cs_n, 1);
        check("reset_sck", sck, 0);
        check("reset_sdi", sdi, 0);
        check("reset_ldac_n", ldac_n, 1);
        check("reset_strobe", sample_strobe, 0);
        check("reset_busy", busy, 0);
        check("reset_state", state_dbg, IDLE);
        rst_n = 1'b1;

        // table vectors; inputs changed mid-sequence must not leak into frame B
        for (int i = 0; i < 5; i++) begin
            set_inputs(vecs[i]);
            exp_q.push_back(vecs[i].exp_a);
            exp_q.push_back(vecs[i].exp_b);
            if (i == 0) enable = 1'b1;
            capture_frame(f, len, found);
            check($sformatf("v%0d_frame_a_seen", i), found, 1);
            exp_f = exp_q.pop_front();
            check($sformatf("v%0d_frame_a", i), f, exp_f);
            check($sformatf("v%0d_len_a", i), len, 32 * SCK_DIV);
            sample_a = ~vecs[i].a;
            sample_b = ~vecs[i].b;
            ch_en_b  = ~vecs[i].en_b;
            capture_frame(f, len, found);
            exp_f = exp_q.pop_front();
            check($sformatf("v%0d_frame_b", i), f, exp_f);
            check($sformatf("v%0d_len_b", i), len, 32 * SCK_DIV);
            wait_for(PIN_STROBE, 1'b1, found);
            check($sformatf("v%0d_strobe_seen", i), found, 1);
        end
        set_inputs(vecs[0]);

        // full-sequence timing
        wait_for(PIN_CS, 1'b0, found);
        check("tm_cs_fall_seen", found, 1);
        t0 = cyc;
        run_len(PIN_CS, 1'b0, len);
        check("tm_cs_low_a", len, 64);
        check("tm_sck_low_at_cs_rise", sck, 0);
        run_len(PIN_CS, 1'b1, len);
        check("tm_gap_ab", len, 4);
        run_len(PIN_CS, 1'b0, len);
        check("tm_cs_low_b", len, 64);
        run_len(PIN_LDAC, 1'b1, len);
        check("tm_gap_ld", len, 4);
        run_len(PIN_LDAC, 1'b0, len);
        check("tm_ldac_low", len, 4);
        check("tm_strobe_on", sample_strobe, 1);
        @(negedge clk);
        check("tm_strobe_off", sample_strobe, 0);
        check("tm_busy_idle", busy, 0);
        wait_for(PIN_CS, 1'b0, found);
        check("tm_frame_period", cyc - t0, SAMPLE_DIV);

        // reset during SHIFT_A bit 7 (sck high phase)
        wait_for(PIN_CS, 1'b0, found);
        repeat (34) @(negedge clk);
        check("rst_pre_sck", sck, 1);
        check("rst_pre_sdi", sdi, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_cs_n", cs_n, 1);
        check("rst_mid_sck", sck, 0);
        check("rst_mid_sdi", sdi, 0);
        check("rst_mid_ldac_n", ldac_n, 1);
        check("rst_mid_strobe", sample_strobe, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_state", state_dbg, IDLE);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 1; k <= SAMPLE_DIV; k++) begin
            @(negedge clk);
            if (k < SAMPLE_DIV && cs_n == 1'b0) bad++;
        end
        check("rst_quiet_cycles", bad, 0);
        check("rst_first_frame", cs_n, 0);

        // enable dropped during SHIFT_B
        run_len(PIN_CS, 1'b0, len);
        run_len(PIN_CS, 1'b1, len);
        len = 0;
        while (cs_n == 1'b0 && len < BOUND) begin
            if (len == 10) enable = 1'b0;
            len++;
            @(negedge clk);
        end
        check("en_drop_len_b", len, 64);
        run_len(PIN_LDAC, 1'b1, len);
        check("en_drop_gap_ld", len, 4);
        run_len(PIN_LDAC, 1'b0, len);
        check("en_drop_ldac", len, 4);
        check("en_drop_strobe", sample_strobe, 1);
        bad = 0;
        repeat (2 * SAMPLE_DIV) begin
            @(negedge clk);
            if (cs_n == 1'b0 || busy == 1'b1 || sample_strobe == 1'b1) bad++;
        end
        check("en_drop_quiet", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
